// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes: physical tag type, free-list geometry,
// and a 2-bit popcount used by the 2-wide alloc/free/commit ports.
package rename_pkg;

  localparam int NUM_PHY   = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHY_WIDTH = $clog2(NUM_PHY);
  localparam int FL_DEPTH  = NUM_PHY - ARCH_REGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);

  typedef logic [PHY_WIDTH-1:0] phy_tag_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Physical register free list for a 2-wide rename stage with commit-time rewind.
// Optional self-check logic is enabled by defining FREELIST_CHECK_EN.
module phys_reg_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                done,
  input  logic [1:0]          alloc_req,
  output logic                alloc_ok,
  output phy_tag_t            rd_phy_new_0,
  output phy_tag_t            rd_phy_new_1,
  input  logic [1:0]          free_valid,
  input  phy_tag_t            free_phy_0,
  input  phy_tag_t            free_phy_1,
  input  logic [1:0]          commit_alloc,
  output logic [FL_PTR_W:0]   free_count,
  output logic                err
);

  localparam int CW = FL_PTR_W + 1;
  localparam int SW = CW + 1;

  typedef logic [FL_PTR_W-1:0] ptr_t;
  typedef logic [CW-1:0]       cnt_t;
  typedef logic [SW-1:0]       sum_t;

  phy_tag_t   fl [FL_DEPTH];
  ptr_t       head, tail, commit_head;
  // Allocated-but-uncommitted count; resolves head==commit_head when all 32 are in flight.
  cnt_t       spec_cnt;

  logic [1:0] n_req, n_free, n_commit;
  logic       rewind;
  ptr_t       head_p1, tail_p1, commit_head_next, head_next;
  cnt_t       cnt_next, spec_next;
  sum_t       cnt_sum;

  assign n_req    = popcnt2(alloc_req);
  assign n_free   = popcnt2(free_valid);
  assign n_commit = popcnt2(commit_alloc);
  assign rewind   = flush | done;

  assign alloc_ok = (cnt_t'(n_req) <= free_count) && !rewind;

  assign head_p1          = head + ptr_t'(1);
  assign tail_p1          = tail + ptr_t'(1);
  assign commit_head_next = commit_head + ptr_t'(n_commit);

  // A lone slot1 request is packed onto the head entry.
  assign rd_phy_new_0 = fl[head];
  assign rd_phy_new_1 = (alloc_req == 2'b10) ? fl[head] : fl[head_p1];

  always_comb begin
    cnt_sum   = {1'b0, free_count} + sum_t'(n_free);
    spec_next = spec_cnt - cnt_t'(n_commit);
    head_next = head;
    if (rewind) begin
      cnt_sum   = cnt_sum + {1'b0, spec_cnt} - sum_t'(n_commit);
      spec_next = '0;
      head_next = commit_head_next;
    end else if (alloc_ok) begin
      cnt_sum   = cnt_sum - sum_t'(n_req);
      spec_next = spec_next + cnt_t'(n_req);
      head_next = head + ptr_t'(n_req);
    end
    cnt_next = cnt_t'(cnt_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      spec_cnt    <= '0;
      free_count  <= cnt_t'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= phy_tag_t'(ARCH_REGS + i);
    end else begin
      head        <= head_next;
      tail        <= tail + ptr_t'(n_free);
      commit_head <= commit_head_next;
      spec_cnt    <= spec_next;
      free_count  <= cnt_next;
      if (free_valid[0]) fl[tail] <= free_phy_0;
      if (free_valid[1]) fl[free_valid[0] ? tail_p1 : tail] <= free_phy_1;
    end
  end

`ifdef FREELIST_CHECK_EN
  localparam int AW = $clog2(ARCH_REGS);

  // Architectural tags currently sitting in the pool after being released once.
  logic [ARCH_REGS-1:0] arch_freed, arch_freed_next;
  logic                 err_r, chk_over, chk_commit, chk_arch, chk_any;
  logic                 low0, low1;

  assign low0 = free_valid[0] && (free_phy_0 < phy_tag_t'(ARCH_REGS));
  assign low1 = free_valid[1] && (free_phy_1 < phy_tag_t'(ARCH_REGS));

  always_comb begin
    chk_over   = cnt_sum > sum_t'(FL_DEPTH);
    chk_commit = cnt_t'(n_commit) > spec_cnt;
    chk_arch   = (low0 && arch_freed[free_phy_0[AW-1:0]]) ||
                 (low1 && arch_freed[free_phy_1[AW-1:0]]) ||
                 (low0 && low1 && (free_phy_0 == free_phy_1));
    chk_any    = chk_over | chk_commit | chk_arch;

    arch_freed_next = arch_freed;
    if (alloc_ok && alloc_req[0] && (rd_phy_new_0 < phy_tag_t'(ARCH_REGS)))
      arch_freed_next[rd_phy_new_0[AW-1:0]] = 1'b0;
    if (alloc_ok && alloc_req[1] && (rd_phy_new_1 < phy_tag_t'(ARCH_REGS)))
      arch_freed_next[rd_phy_new_1[AW-1:0]] = 1'b0;
    if (low0) arch_freed_next[free_phy_0[AW-1:0]] = 1'b1;
    if (low1) arch_freed_next[free_phy_1[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r      <= 1'b0;
      arch_freed <= '0;
    end else begin
      arch_freed <= arch_freed_next;
      if (chk_any) err_r <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && chk_any && !err_r)
      $error("phys_reg_free_list: over=%0b commit=%0b arch=%0b", chk_over, chk_commit, chk_arch);
  end
`endif

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized + directed bench for phys_reg_free_list against a queue-based model
// of the free pool, speculative allocations and mapped (freeable) tags.
module tb_phys_reg_free_list;
  import rename_pkg::*;

  logic           clk = 1'b0;
  logic           rst, flush, done;
  logic [1:0]     alloc_req, free_valid, commit_alloc;
  logic           alloc_ok, err;
  phy_tag_t       rd_phy_new_0, rd_phy_new_1, free_phy_0, free_phy_1;
  logic [FL_PTR_W:0] free_count;

  int total = 0;
  int bad   = 0;

  int free_q[$];
  int spec_q[$];
  int mapped_q[$];

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .flush(flush), .done(done),
    .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .rd_phy_new_0(rd_phy_new_0), .rd_phy_new_1(rd_phy_new_1),
    .free_valid(free_valid), .free_phy_0(free_phy_0), .free_phy_1(free_phy_1),
    .commit_alloc(commit_alloc), .free_count(free_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; done = 1'b0; alloc_req = 2'b00;
    free_valid = 2'b00; commit_alloc = 2'b00; free_phy_0 = '0; free_phy_1 = '0;
    free_q.delete(); spec_q.delete(); mapped_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) free_q.push_back(ARCH_REGS + i);
    for (int i = 0; i < ARCH_REGS; i++) mapped_q.push_back(i);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One clock: drive, check combinational outputs and registered count, advance model.
  task automatic step(input logic [1:0] req, input logic fl_i, input logic dn_i,
                      input logic [1:0] fv, input int p0, input int p1,
                      input logic [1:0] ca);
    int  nreq, nc;
    bit  exp_ok;
    alloc_req = req; flush = fl_i; done = dn_i; free_valid = fv;
    free_phy_0 = phy_tag_t'(p0); free_phy_1 = phy_tag_t'(p1); commit_alloc = ca;
    #1;
    nreq   = int'(req[0]) + int'(req[1]);
    nc     = int'(ca[0]) + int'(ca[1]);
    exp_ok = (nreq <= free_q.size()) && !fl_i && !dn_i;
    check_eq("free_count", int'(free_count), free_q.size());
    check_eq("alloc_ok", int'(alloc_ok), int'(exp_ok));
    check_eq("err", int'(err), 0);
    if (req == 2'b11 && free_q.size() >= 2) begin
      check_eq("tag0", int'(rd_phy_new_0), free_q[0]);
      check_eq("tag1", int'(rd_phy_new_1), free_q[1]);
    end else if (req == 2'b01 && free_q.size() >= 1) begin
      check_eq("tag0_single", int'(rd_phy_new_0), free_q[0]);
    end else if (req == 2'b10 && free_q.size() >= 1) begin
      check_eq("tag1_packed", int'(rd_phy_new_1), free_q[0]);
    end
    @(posedge clk);
    for (int k = 0; k < nc; k++) mapped_q.push_back(spec_q.pop_front());
    if (exp_ok) for (int k = 0; k < nreq; k++) spec_q.push_back(free_q.pop_front());
    if (fl_i || dn_i) begin
      free_q = {spec_q, free_q};
      spec_q.delete();
    end
    if (fv[0]) free_q.push_back(p0);
    if (fv[1]) free_q.push_back(p1);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
  endtask

  int t0, t1, nf, nc, credits, idx;
  logic [1:0] rq, fv, ca;

  initial begin
    // Reset state and first allocation
    do_reset();
    check_eq("rst_count", int'(free_count), FL_DEPTH);
    check_eq("rst_err", int'(err), 0);
    step(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    alloc_req = 2'b11; #1;
    check_eq("t1_count", int'(free_count), 30);
    check_eq("t1_next_tag0", int'(rd_phy_new_0), 34);
    check_eq("t1_next_tag1", int'(rd_phy_new_1), 35);

    // Drain, refused alloc, same-cycle free visible only next cycle
    for (int i = 0; i < 15; i++) step(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    check_eq("t2_empty", int'(free_count), 0);
    step(2'b01, 1'b0, 1'b0, 2'b01, 5, 0, 2'b00);
    alloc_req = 2'b01; #1;
    check_eq("t2_ok_after_free", int'(alloc_ok), 1);
    check_eq("t2_tag_reuse", int'(rd_phy_new_0), 5);
    step(2'b01, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);

    // Allocate 6, commit 2, flush
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    step(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b11);
    step(2'b00, 1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
    alloc_req = 2'b11; #1;
    check_eq("t3_count", int'(free_count), FL_DEPTH - 2);
    check_eq("t3_restart", int'(rd_phy_new_0), 34);

    // Pointer wrap with alloc/commit/free pairs
    do_reset();
    for (int i = 0; i < 40; i++) begin
      fv = (i > 1) ? 2'b01 : 2'b00;
      t0 = (i > 1) ? mapped_q.pop_front() : 0;
      step(2'b01, 1'b0, 1'b0, fv, t0, 0, (i > 0) ? 2'b01 : 2'b00);
    end
    check_eq("t4_count", int'(free_count), 30);

    // Flush colliding with alloc, frees and a commit
    do_reset();
    step(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    step(2'b11, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    step(2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b01);
    t0 = mapped_q.pop_front(); t1 = mapped_q.pop_front();
    step(2'b11, 1'b1, 1'b0, 2'b11, t0, t1, 2'b01);
    alloc_req = 2'b11; #1;
    check_eq("t5_count", int'(free_count), FL_DEPTH);
    check_eq("t5_head", int'(rd_phy_new_0), 34);

`ifdef FREELIST_CHECK_EN
    // Overflow sets a sticky error
    do_reset();
    step(2'b01, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
    free_valid = 2'b11; free_phy_0 = phy_tag_t'(1); free_phy_1 = phy_tag_t'(2);
    @(posedge clk); @(negedge clk);
    free_valid = 2'b00;
    #1;
    check_eq("t6_err_set", int'(err), 1);
    repeat (3) @(negedge clk);
    check_eq("t6_err_held", int'(err), 1);
    do_reset();
    check_eq("t6_err_clr", int'(err), 0);
`endif

    // Randomized legal traffic
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rq = 2'($urandom_range(0, 3));
      credits = FL_DEPTH - free_q.size() - spec_q.size();
      nf = $urandom_range(0, 2);
      if (nf > credits) nf = credits;
      nc = $urandom_range(0, 2);
      if (nc > spec_q.size()) nc = spec_q.size();
      t0 = 0; t1 = 0;
      if (nf == 2) begin
        idx = $urandom_range(0, mapped_q.size() - 1); t0 = mapped_q[idx]; mapped_q.delete(idx);
        idx = $urandom_range(0, mapped_q.size() - 1); t1 = mapped_q[idx]; mapped_q.delete(idx);
        fv = 2'b11;
      end else if (nf == 1) begin
        idx = $urandom_range(0, mapped_q.size() - 1);
        if ($urandom_range(0, 1) == 0) begin t0 = mapped_q[idx]; fv = 2'b01; end
        else begin t1 = mapped_q[idx]; fv = 2'b10; end
        mapped_q.delete(idx);
      end else begin
        fv = 2'b00;
      end
      if (nc == 2) ca = 2'b11;
      else if (nc == 1) ca = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      else ca = 2'b00;
      step(rq, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0), fv, t0, t1, ca);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
